ibex_fetch_unit: RTL

Instruction-fetch responder to the core controller. It consumes the controller's fetch-request and PC-redirect commands and computes the redirect target. It issues word requests on the instruction memory request/grant/rvalid bus, buffers responses in a 2-entry FIFO, and presents one instruction per handshake to the ID stage (instr_valid, instruction word, PC, fetch error). RV32 uncompressed fetch only; compressed/plus2 handling is out of scope.

---
 rtl/ibex_fetch_unit.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ibex_fetch_unit.sv
// ibex_fetch_unit: RV32 word fetch with a 2-entry response buffer feeding the ID register.
// Optional FETCH_DISCARD_CNT_EN adds discard_cnt_o, a saturating count of dropped responses.
module ibex_fetch_unit #(
  parameter logic [31:0] DmHaltAddr      = 32'h1A110800,
  parameter logic [31:0] DmExceptionAddr = 32'h1A110808,
  parameter int unsigned FifoDepth       = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        pc_set_i,
  input  logic [2:0]  pc_mux_i,
  input  logic [1:0]  exc_pc_mux_i,
  input  logic [5:0]  exc_cause_i,
  input  logic [31:0] boot_addr_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_depc_i,
  input  logic        id_in_ready_i,
  input  logic        instr_valid_clear_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        instr_valid_id_o,
  output logic [31:0] instr_rdata_id_o,
  output logic [31:0] pc_id_o,
  output logic        instr_fetch_err_o,
`ifdef FETCH_DISCARD_CNT_EN
  output logic        fetch_busy_o,
  output logic [15:0] discard_cnt_o
`else
  output logic        fetch_busy_o
`endif
);

  logic [31:0] target, exc_target;
  logic        unused_irq_flag;
  assign unused_irq_flag = exc_cause_i[5];

  always_comb begin
    case (exc_pc_mux_i)
      2'd0:    exc_target = {csr_mtvec_i[31:8], 8'h00};
      2'd1:    exc_target = {csr_mtvec_i[31:8], 1'b0, exc_cause_i[4:0], 2'b00};
      2'd2:    exc_target = DmHaltAddr;
      default: exc_target = DmExceptionAddr;
    endcase
    case (pc_mux_i)
      3'd1:    target = branch_target_i;
      3'd2:    target = exc_target;
      3'd3:    target = csr_mepc_i;
      3'd4:    target = csr_depc_i;
      default: target = {boot_addr_i[31:8], 8'h80};
    endcase
    target[1:0] = 2'b00;
  end

  logic [31:0] fetch_addr_q, fetch_addr_d, resp_pc_q, resp_pc_d, stale_addr_q;
  logic [1:0]  outstanding_q, outstanding_d, discard_q, discard_d, fifo_cnt_q, fifo_cnt_d;
  logic        pend_q, pend_d, stale_q, stale_d, err_stop_q, err_stop_d;
  logic [31:0] fifo_rdata_q [2], fifo_rdata_d [2], fifo_pc_q [2], fifo_pc_d [2];
  logic [1:0]  fifo_err_q, fifo_err_d;
  logic        id_valid_q, id_valid_d, id_err_q, id_err_d;
  logic [31:0] id_rdata_q, id_rdata_d, id_pc_q, id_pc_d;

  logic [2:0]  in_flight;
  logic        can_issue, gnt_fire, rsp_push, pop, wr_idx;

  assign in_flight    = {1'b0, fifo_cnt_q} + {1'b0, outstanding_q};
  assign can_issue    = req_i & ~err_stop_q & (in_flight < 3'(FifoDepth));
  assign instr_req_o  = pend_q | can_issue;
  // A request caught by a redirect keeps its original address until granted.
  assign instr_addr_o = stale_q ? stale_addr_q : fetch_addr_q;
  assign gnt_fire     = instr_req_o & instr_gnt_i;
  assign rsp_push     = instr_rvalid_i & ~pc_set_i & (discard_q == 2'd0);
  assign pop          = (fifo_cnt_q != 2'd0) & id_in_ready_i & ~pc_set_i;
  assign wr_idx       = fifo_cnt_q[0] & ~pop;
  assign pend_d       = instr_req_o & ~instr_gnt_i;
  assign stale_d      = pend_d & (pc_set_i | stale_q);

  always_comb begin
    outstanding_d = outstanding_q + {1'b0, gnt_fire} - {1'b0, instr_rvalid_i};
    fetch_addr_d  = fetch_addr_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;
    err_stop_d    = err_stop_q;
    if (pc_set_i) begin
      // Everything still in flight after this cycle belongs to the old stream.
      fetch_addr_d = target;
      resp_pc_d    = target;
      discard_d    = outstanding_d;
      err_stop_d   = 1'b0;
    end else begin
      if (gnt_fire && !stale_q) fetch_addr_d = fetch_addr_q + 32'd4;
      if (instr_rvalid_i && discard_q != 2'd0) discard_d = discard_q - 2'd1;
      if (gnt_fire && stale_q) discard_d = discard_d + 2'd1;
      if (rsp_push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        if (instr_err_i) err_stop_d = 1'b1;
      end
    end
  end

  always_comb begin
    fifo_rdata_d = fifo_rdata_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_err_d   = fifo_err_q;
    if (pop) begin
      fifo_rdata_d[0] = fifo_rdata_q[1];
      fifo_pc_d[0]    = fifo_pc_q[1];
      fifo_err_d[0]   = fifo_err_q[1];
    end
    if (rsp_push) begin
      fifo_rdata_d[wr_idx] = instr_err_i ? 32'h0 : instr_rdata_i;
      fifo_pc_d[wr_idx]    = resp_pc_q;
      fifo_err_d[wr_idx]   = instr_err_i;
    end
    fifo_cnt_d = pc_set_i ? 2'd0 : fifo_cnt_q + {1'b0, rsp_push} - {1'b0, pop};

    id_valid_d = id_valid_q;
    id_rdata_d = id_rdata_q;
    id_pc_d    = id_pc_q;
    id_err_d   = id_err_q;
    if (pop) begin
      id_valid_d = 1'b1;
      id_rdata_d = fifo_rdata_q[0];
      id_pc_d    = fifo_pc_q[0];
      id_err_d   = fifo_err_q[0];
    end else if (instr_valid_clear_i) begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_addr_q  <= '0;
      resp_pc_q     <= '0;
      stale_addr_q  <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      fifo_cnt_q    <= '0;
      pend_q        <= 1'b0;
      stale_q       <= 1'b0;
      err_stop_q    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_rdata_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
      fifo_err_q    <= '0;
      id_valid_q    <= 1'b0;
      id_rdata_q    <= '0;
      id_pc_q       <= '0;
      id_err_q      <= 1'b0;
    end else begin
      fetch_addr_q  <= fetch_addr_d;
      resp_pc_q     <= resp_pc_d;
      stale_addr_q  <= instr_addr_o;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fifo_cnt_q    <= fifo_cnt_d;
      pend_q        <= pend_d;
      stale_q       <= stale_d;
      err_stop_q    <= err_stop_d;
      fifo_rdata_q  <= fifo_rdata_d;
      fifo_pc_q     <= fifo_pc_d;
      fifo_err_q    <= fifo_err_d;
      id_valid_q    <= id_valid_d;
      id_rdata_q    <= id_rdata_d;
      id_pc_q       <= id_pc_d;
      id_err_q      <= id_err_d;
    end
  end

  assign instr_valid_id_o  = id_valid_q;
  assign instr_rdata_id_o  = id_rdata_q;
  assign pc_id_o           = id_pc_q;
  assign instr_fetch_err_o = id_err_q;
  assign fetch_busy_o      = (outstanding_q != 2'd0) | (fifo_cnt_q != 2'd0);

`ifdef FETCH_DISCARD_CNT_EN
  logic [15:0] discard_cnt_q, discard_cnt_d;
  always_comb begin
    discard_cnt_d = discard_cnt_q;
    if (instr_rvalid_i && !rsp_push && discard_cnt_q != 16'hFFFF)
      discard_cnt_d = discard_cnt_q + 16'd1;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) discard_cnt_q <= '0;
    else         discard_cnt_q <= discard_cnt_d;
  end
  assign discard_cnt_o = discard_cnt_q;
`endif

endmodule
